// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with two combinational read ports,
// one synchronous write port, a per-register pending scoreboard and a
// pending-entry counter used by decode for RAW hazard detection.
//
// Ports:
//   clk, rst (async, active-high)
//   wr_en / wr_addr / wr_data          writeback port
//   rd_enN / rd_addrN -> rd_dataN, rd_rdyN (N = 1, 2) operand read ports
//   rsv_en / rsv_addr                  mark a register pending
//   pend_cnt                           number of pending registers
//
// Optional: define REG_FILE_BYPASS_EN to forward same-cycle write data
// to matching read ports.

module reg_file_sb #(
    parameter  int DATA_W   = 16,
    parameter  int NUM_REGS = 16,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(NUM_REGS),
    localparam int CNT_W    = $clog2(NUM_REGS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en1,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    output logic              rd_rdy1,
    input  logic              rd_en2,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_rdy2,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [CNT_W-1:0]  pend_cnt
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] pend_nxt;
    logic [CNT_W-1:0]    cnt;

    logic wr_ok;
    logic rsv_ok;
    logic inc;
    logic dec;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign wr_ok  = wr_en && !is_zero(wr_addr);
    assign rsv_ok = rsv_en && !is_zero(rsv_addr);

    // A reserve that lands on the register being written keeps it pending,
    // so such a write must not decrement the count.
    assign inc = rsv_ok && !pend[rsv_addr];
    assign dec = wr_ok && pend[wr_addr]
                 && !(rsv_ok && (rsv_addr == wr_addr));

    always_comb begin
        pend_nxt = pend;
        if (wr_ok) pend_nxt[wr_addr] = 1'b0;
        if (rsv_ok) pend_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            pend <= '0;
            cnt  <= '0;
        end else begin
            if (wr_ok) regs[wr_addr] <= wr_data;
            pend <= pend_nxt;
            cnt  <= cnt + CNT_W'(inc) - CNT_W'(dec);
        end
    end

    assign pend_cnt = cnt;

    always_comb begin
        rd_data1 = '0;
        rd_rdy1  = 1'b1;
        if (!rst && rd_en1 && !is_zero(rd_addr1)) begin
`ifdef REG_FILE_BYPASS_EN
            if (wr_ok && (rd_addr1 == wr_addr)) begin
                rd_data1 = wr_data;
            end else begin
                rd_data1 = regs[rd_addr1];
                rd_rdy1  = !pend[rd_addr1];
            end
`else
            rd_data1 = regs[rd_addr1];
            rd_rdy1  = !pend[rd_addr1];
`endif
        end
    end

    always_comb begin
        rd_data2 = '0;
        rd_rdy2  = 1'b1;
        if (!rst && rd_en2 && !is_zero(rd_addr2)) begin
`ifdef REG_FILE_BYPASS_EN
            if (wr_ok && (rd_addr2 == wr_addr)) begin
                rd_data2 = wr_data;
            end else begin
                rd_data2 = regs[rd_addr2];
                rd_rdy2  = !pend[rd_addr2];
            end
`else
            rd_data2 = regs[rd_addr2];
            rd_rdy2  = !pend[rd_addr2];
`endif
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed plus randomized bench for reg_file_sb with
// a behavioural model of register contents and pending set.

module tb_reg_file_sb;

    localparam int DW = 16;
    localparam int NR = 16;
    localparam int AW = 4;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en1;
    logic [AW-1:0] rd_addr1;
    logic [DW-1:0] rd_data1;
    logic          rd_rdy1;
    logic          rd_en2;
    logic [AW-1:0] rd_addr2;
    logic [DW-1:0] rd_data2;
    logic          rd_rdy2;
    logic          rsv_en;
    logic [AW-1:0] rsv_addr;
    logic [CW-1:0] pend_cnt;

    int checks = 0;
    int errors = 0;

    int unsigned m_regs [NR];
    bit          m_pend [NR];

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en1   (rd_en1),
        .rd_addr1 (rd_addr1),
        .rd_data1 (rd_data1),
        .rd_rdy1  (rd_rdy1),
        .rd_en2   (rd_en2),
        .rd_addr2 (rd_addr2),
        .rd_data2 (rd_data2),
        .rd_rdy2  (rd_rdy2),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .pend_cnt (pend_cnt)
    );

    task automatic chk(input string tag, input int unsigned obs,
                       input int unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = 0;
            m_pend[i] = 0;
        end
    endtask

    function automatic int unsigned m_count();
        int unsigned n = 0;
        for (int i = 0; i < NR; i++) n += m_pend[i];
        return n;
    endfunction

    function automatic bit bypass_hit(input bit en, input int a);
`ifdef REG_FILE_BYPASS_EN
        return en && wr_en && (a == int'(wr_addr)) && (a != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int unsigned exp_data(input bit en, input int a);
        if (rst || !en || a == 0) return 0;
        if (bypass_hit(en, a)) return int'(wr_data);
        return m_regs[a];
    endfunction

    function automatic int unsigned exp_rdy(input bit en, input int a);
        if (rst || !en || a == 0) return 1;
        if (bypass_hit(en, a)) return 1;
        return m_pend[a] ? 0 : 1;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".d1"}, rd_data1, exp_data(rd_en1, int'(rd_addr1)));
        chk({tag, ".r1"}, rd_rdy1, exp_rdy(rd_en1, int'(rd_addr1)));
        chk({tag, ".d2"}, rd_data2, exp_data(rd_en2, int'(rd_addr2)));
        chk({tag, ".r2"}, rd_rdy2, exp_rdy(rd_en2, int'(rd_addr2)));
        chk({tag, ".cnt"}, pend_cnt, m_count());
    endtask

    task automatic drive(input bit we, input int wa, input int wd,
                         input bit e1, input int a1,
                         input bit e2, input int a2,
                         input bit re, input int ra);
        wr_en    = we;
        wr_addr  = AW'(wa);
        wr_data  = DW'(wd);
        rd_en1   = e1;
        rd_addr1 = AW'(a1);
        rd_en2   = e2;
        rd_addr2 = AW'(a2);
        rsv_en   = re;
        rsv_addr = AW'(ra);
        #1;
    endtask

    // Register 0 is hardwired, so writes/reserves to it are dropped.
    task automatic tick();
        @(posedge clk);
        if (wr_en && wr_addr != 0) begin
            m_regs[wr_addr] = int'(wr_data);
            m_pend[wr_addr] = 0;
        end
        if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1;
        #1;
    endtask

    initial begin
        model_clear();
        rst = 1'b1;
        drive(0, 0, 0, 1, 5, 1, 6, 0, 0);
        #10;
        check_all("reset");
        rst = 1'b0;

        drive(1, 5, 'hBEEF, 1, 5, 1, 6, 1, 6);
        tick();
        check_all("pre_rst");
        chk("pre_rst.val", rd_data1, 'hBEEF);
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        chk("async_rst.d1", rd_data1, 0);
        chk("async_rst.r2", rd_rdy2, 1);
        chk("async_rst.cnt", pend_cnt, 0);
        #1;
        rst = 1'b0;
        #1;
        check_all("post_rst");

        drive(1, 3, 'h1234, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 3, 0, 3, 0, 0);
        check_all("wr_rd");
        chk("wr_rd.val", rd_data1, 'h1234);
        chk("wr_rd.dis", rd_data2, 0);

        drive(0, 0, 0, 0, 0, 1, 7, 1, 7);
        tick();
        drive(0, 0, 0, 0, 0, 1, 7, 0, 0);
        check_all("rsv7");
        chk("rsv7.rdy", rd_rdy2, 0);
        chk("rsv7.cnt", pend_cnt, 1);
        tick();
        tick();
        drive(1, 7, 'h00AA, 0, 0, 1, 7, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 7, 0, 0);
        check_all("wr7");
        chk("wr7.rdy", rd_rdy2, 1);
        chk("wr7.cnt", pend_cnt, 0);
        chk("wr7.val", rd_data2, 'h00AA);

        drive(0, 0, 0, 0, 0, 0, 0, 1, 2);
        tick();
        drive(1, 2, 'h5555, 0, 0, 0, 0, 1, 2);
        tick();
        drive(0, 0, 0, 1, 2, 1, 4, 0, 0);
        check_all("simul_same");
        chk("simul_same.val", rd_data1, 'h5555);
        chk("simul_same.rdy", rd_rdy1, 0);
        chk("simul_same.cnt", pend_cnt, 1);
        drive(1, 2, 'h6666, 0, 0, 0, 0, 1, 4);
        tick();
        drive(0, 0, 0, 1, 2, 1, 4, 0, 0);
        check_all("simul_diff");
        chk("simul_diff.cnt", pend_cnt, 1);
        chk("simul_diff.r4", rd_rdy2, 0);
        chk("simul_diff.r2", rd_rdy1, 1);
        drive(1, 4, 'h0044, 0, 0, 0, 0, 0, 0);
        tick();

        drive(1, 0, 'hFFFF, 0, 0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 1, 0, 1, 0, 0, 0);
        check_all("zero");
        chk("zero.val", rd_data1, 0);
        chk("zero.rdy", rd_rdy1, 1);
        chk("zero.cnt", pend_cnt, 0);

        drive(1, 9, 'h0001, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 9, 'hC0DE, 1, 9, 0, 0, 0, 0);
        check_all("byp_pre");
`ifdef REG_FILE_BYPASS_EN
        chk("byp_pre.val", rd_data1, 'hC0DE);
`else
        chk("byp_pre.val", rd_data1, 'h0001);
`endif
        tick();
        drive(0, 0, 0, 1, 9, 0, 0, 0, 0);
        chk("byp_post.val", rd_data1, 'hC0DE);

        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 15),
                  $urandom_range(0, 'hFFFF),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 15));
            check_all("rand");
            tick();
            if (n == 250) begin
                #2;
                rst = 1'b1;
                model_clear();
                #1;
                check_all("rand_rst");
                rst = 1'b0;
                #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
